// File: rtl/wb_commit_buffer_pkg.sv
// Shared definitions for the writeback commit buffer and the load aligner.
package wb_commit_buffer_pkg;

  // Load size encodings, as carried on in_ld_size.
  typedef enum logic [1:0] {
    LD_B   = 2'b00,
    LD_H   = 2'b01,
    LD_W   = 2'b10,
    LD_RSV = 2'b11
  } ld_size_e;

  // Entry field widths. Default address and PC widths are also the
  // default parameter values of the buffer.
  localparam int DATA_W      = 32;
  localparam int DEF_RF_AW   = 5;
  localparam int DEF_PC_W    = 32;

  // Golden-trace port widths are fixed regardless of parameters.
  localparam int TRACE_WEN_W  = 4;
  localparam int TRACE_PC_W   = 32;
  localparam int TRACE_RNUM_W = 5;

  // Sign- or zero-extend a byte to a full data word.
  function automatic logic [DATA_W-1:0] ext_byte(input logic [7:0] b,
                                                 input logic       uns);
    return {{(DATA_W-8){~uns & b[7]}}, b};
  endfunction

  // Sign- or zero-extend a halfword to a full data word.
  function automatic logic [DATA_W-1:0] ext_half(input logic [15:0] h,
                                                 input logic        uns);
    return {{(DATA_W-16){~uns & h[15]}}, h};
  endfunction

endpackage

// File: rtl/wb_commit_buffer_load_align_ext.sv
// Load lane selection and sign/zero extension. Purely combinational so the
// MEM stage can reuse it. Misaligned halves/words and the reserved size
// produce zero rather than a partially shifted value.
module load_align_ext
  import wb_commit_buffer_pkg::*;
(
  input  logic [DATA_W-1:0] i_rdata,
  input  logic [1:0]        i_size,
  input  logic              i_unsigned,
  input  logic [1:0]        i_addr_lo,
  output logic [DATA_W-1:0] o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Pick the byte lane addressed by the low address bits.
  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
  end

  // Pick the halfword lane; bit 0 is checked for alignment separately.
  always_comb begin
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  // Apply the size, alignment rule and extension.
  always_comb begin
    o_result = '0;
    case (ld_size_e'(i_size))
      LD_B: o_result = ext_byte(w_byte, i_unsigned);
      LD_H: begin
        if (!i_addr_lo[0]) o_result = ext_half(w_half, i_unsigned);
      end
      LD_W: begin
        if (i_addr_lo == 2'b00) o_result = i_rdata;
      end
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/wb_commit_buffer.sv
// Writeback commit buffer: an in-order FIFO between MEM and the shared
// regfile write port. Results are aligned/extended on enqueue, retire in
// order when the write port grants (or immediately for non-writing
// entries), and every buffered entry feeds operand forwarding.
//
// Handshakes (valid/ready):
//   MEM -> WB : a transfer happens on a cycle where in_valid & in_allow.
//               in_allow may depend combinationally on rf_wready, so a
//               full buffer still accepts when its head retires that cycle.
//   WB -> RF  : a write happens on a cycle where rf_we & rf_wready. Entries
//               with no regfile write retire without waiting for rf_wready.
module wb_commit_buffer
  import wb_commit_buffer_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int RF_AW = DEF_RF_AW,
  parameter int PC_W  = DEF_PC_W
) (
  input  logic                    clk,
  input  logic                    resetn,
  // MEM-side enqueue
  input  logic                    in_valid,
  output logic                    in_allow,
  input  logic [PC_W-1:0]         in_pc,
  input  logic                    in_rf_we,
  input  logic [RF_AW-1:0]        in_rd,
  input  logic                    in_is_load,
  input  logic [1:0]              in_ld_size,
  input  logic                    in_ld_unsigned,
  input  logic [1:0]              in_addr_lo,
  input  logic [DATA_W-1:0]       in_ram_rdata,
  input  logic [DATA_W-1:0]       in_alu_result,
  // Regfile write port
  output logic                    rf_we,
  output logic [RF_AW-1:0]        rf_waddr,
  output logic [DATA_W-1:0]       rf_wdata,
  input  logic                    rf_wready,
  // Operand forwarding
  input  logic [RF_AW-1:0]        byp_raddr1,
  input  logic [RF_AW-1:0]        byp_raddr2,
  output logic                    byp_hit1,
  output logic                    byp_hit2,
  output logic [DATA_W-1:0]       byp_data1,
  output logic [DATA_W-1:0]       byp_data2,
  // Golden trace
  output logic [TRACE_PC_W-1:0]   debug_wb_pc,
  output logic [TRACE_WEN_W-1:0]  debug_wb_rf_wen,
  output logic [TRACE_RNUM_W-1:0] debug_wb_rf_wnum,
  output logic [DATA_W-1:0]       debug_wb_rf_wdata
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Entry storage; r_vld marks occupied slots.
  logic [PC_W-1:0]   r_pc   [DEPTH];
  logic              r_we   [DEPTH];
  logic [RF_AW-1:0]  r_rd   [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]  r_vld;

  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  logic [DATA_W-1:0] w_ld_result;
  logic [DATA_W-1:0] w_enq_data;
  logic              w_enq_we;
  logic              w_head_vld;
  logic              w_head_we;
  logic              w_full;
  logic              w_retire;
  logic              w_push;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Youngest-wins forwarding: walk from head (oldest) to tail so later
  // matches overwrite earlier ones. Valid entries are contiguous from head.
  function automatic logic [DATA_W:0] byp_lookup(input logic [RF_AW-1:0] raddr);
    logic [PTR_W-1:0] idx;
    logic [DATA_W:0]  res;
    res = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = r_head + PTR_W'(k);
      if ((raddr != '0) && r_vld[idx] && r_we[idx] && (r_rd[idx] == raddr))
        res = {1'b1, r_data[idx]};
    end
    return res;
  endfunction

  load_align_ext u_align (
    .i_rdata    (in_ram_rdata),
    .i_size     (in_ld_size),
    .i_unsigned (in_ld_unsigned),
    .i_addr_lo  (in_addr_lo),
    .o_result   (w_ld_result)
  );

  assign w_enq_data = in_is_load ? w_ld_result : in_alu_result;
  // Writes to r0 are dropped here so nothing downstream has to special-case it.
  assign w_enq_we   = in_rf_we & (in_rd != '0);

  assign w_head_vld = r_vld[r_head];
  assign w_head_we  = r_we[r_head];
  assign w_full     = (r_count == FULL_CNT);

  // Nothing retires or writes while reset is held, so a reset mid-stream
  // never leaks a discarded entry onto the write port or the trace.
  assign w_retire = resetn & w_head_vld & (w_head_we ? rf_wready : 1'b1);
  assign in_allow = ~w_full | w_retire;
  assign w_push   = resetn & in_valid & in_allow;

  // Pointer, occupancy and valid-bit bookkeeping.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_vld   <= '0;
    end else begin
      // Clear before set: with head==tail on a full push+pop the slot stays valid.
      if (w_retire) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= ptr_next(r_head);
      end
      if (w_push) begin
        r_vld[r_tail] <= 1'b1;
        r_tail        <= ptr_next(r_tail);
      end
      case ({w_push, w_retire})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry payload capture at the tail; payload needs no reset because
  // every use is qualified by r_vld.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc[r_tail]   <= in_pc;
      r_we[r_tail]   <= w_enq_we;
      r_rd[r_tail]   <= in_rd;
      r_data[r_tail] <= w_enq_data;
    end
  end

  // Regfile write port always presents the head entry, zero when empty.
  always_comb begin
    rf_we    = resetn & w_head_vld & w_head_we;
    rf_waddr = '0;
    rf_wdata = '0;
    if (w_head_vld) begin
      rf_waddr = r_rd[r_head];
      rf_wdata = r_data[r_head];
    end
  end

  // Forwarding for both ID read ports.
  always_comb begin
    {byp_hit1, byp_data1} = byp_lookup(byp_raddr1);
    {byp_hit2, byp_data2} = byp_lookup(byp_raddr2);
  end

  // Golden trace, driven only in a retire cycle.
  always_comb begin
    debug_wb_pc       = '0;
    debug_wb_rf_wen   = '0;
    debug_wb_rf_wnum  = '0;
    debug_wb_rf_wdata = '0;
    if (w_retire) begin
      debug_wb_pc       = TRACE_PC_W'(r_pc[r_head]);
      debug_wb_rf_wen   = {TRACE_WEN_W{w_head_we}};
      debug_wb_rf_wnum  = TRACE_RNUM_W'(r_rd[r_head]);
      debug_wb_rf_wdata = r_data[r_head];
    end
  end

endmodule

// File: tb/tb_wb_commit_buffer.sv
// Bench for wb_commit_buffer: a DEPTH=2 instance (u_d2) and a DEPTH=4
// instance (u_d4) share all inputs; each phase checks one of them.
module tb_wb_commit_buffer;
  import wb_commit_buffer_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic resetn;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared inputs ----------------
  logic        in_valid, in_rf_we, in_is_load, in_ld_unsigned, rf_wready;
  logic [31:0] in_pc, in_ram_rdata, in_alu_result;
  logic [4:0]  in_rd, byp_raddr1, byp_raddr2;
  logic [1:0]  in_ld_size, in_addr_lo;

  // ---------------- DEPTH=2 outputs ----------------
  logic        a_allow, a_rf_we, a_hit1, a_hit2;
  logic [4:0]  a_waddr, a_dwnum;
  logic [31:0] a_wdata, a_data1, a_data2, a_dpc, a_dwdata;
  logic [3:0]  a_dwen;

  // ---------------- DEPTH=4 outputs ----------------
  logic        b_allow, b_rf_we, b_hit1, b_hit2;
  logic [4:0]  b_waddr, b_dwnum;
  logic [31:0] b_wdata, b_data1, b_data2, b_dpc, b_dwdata;
  logic [3:0]  b_dwen;

  wb_commit_buffer #(.DEPTH(2), .RF_AW(5), .PC_W(32)) u_d2 (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_allow(a_allow), .in_pc(in_pc),
    .in_rf_we(in_rf_we), .in_rd(in_rd), .in_is_load(in_is_load),
    .in_ld_size(in_ld_size), .in_ld_unsigned(in_ld_unsigned),
    .in_addr_lo(in_addr_lo), .in_ram_rdata(in_ram_rdata),
    .in_alu_result(in_alu_result),
    .rf_we(a_rf_we), .rf_waddr(a_waddr), .rf_wdata(a_wdata),
    .rf_wready(rf_wready),
    .byp_raddr1(byp_raddr1), .byp_raddr2(byp_raddr2),
    .byp_hit1(a_hit1), .byp_hit2(a_hit2),
    .byp_data1(a_data1), .byp_data2(a_data2),
    .debug_wb_pc(a_dpc), .debug_wb_rf_wen(a_dwen),
    .debug_wb_rf_wnum(a_dwnum), .debug_wb_rf_wdata(a_dwdata)
  );

  wb_commit_buffer #(.DEPTH(4), .RF_AW(5), .PC_W(32)) u_d4 (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_allow(b_allow), .in_pc(in_pc),
    .in_rf_we(in_rf_we), .in_rd(in_rd), .in_is_load(in_is_load),
    .in_ld_size(in_ld_size), .in_ld_unsigned(in_ld_unsigned),
    .in_addr_lo(in_addr_lo), .in_ram_rdata(in_ram_rdata),
    .in_alu_result(in_alu_result),
    .rf_we(b_rf_we), .rf_waddr(b_waddr), .rf_wdata(b_wdata),
    .rf_wready(rf_wready),
    .byp_raddr1(byp_raddr1), .byp_raddr2(byp_raddr2),
    .byp_hit1(b_hit1), .byp_hit2(b_hit2),
    .byp_data1(b_data1), .byp_data2(b_data2),
    .debug_wb_pc(b_dpc), .debug_wb_rf_wen(b_dwen),
    .debug_wb_rf_wnum(b_dwnum), .debug_wb_rf_wdata(b_dwdata)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [36:0] exp_q[$];   // {rd, data} in expected retire order

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_alu(input logic v, input logic [31:0] pc, input logic we,
                           input logic [4:0] rd, input logic [31:0] alu);
    in_valid       = v;
    in_pc          = pc;
    in_rf_we       = we;
    in_rd          = rd;
    in_is_load     = 1'b0;
    in_ld_size     = LD_W;
    in_ld_unsigned = 1'b0;
    in_addr_lo     = 2'd0;
    in_ram_rdata   = 32'h0;
    in_alu_result  = alu;
  endtask

  task automatic idle();
    drive_alu(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  // ---------------- load extension vectors ----------------
  typedef struct {
    logic        is_load;
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  lo;
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------- main test ----------------
  initial begin
    logic [36:0] e;
    int sent;
    int got;
    int cyc;

    vecs[0]  = '{1'b0, LD_W,   1'b0, 2'd0, 32'h8001_F07F, 32'h1234_5678, 32'h1234_5678};
    vecs[1]  = '{1'b1, LD_B,   1'b0, 2'd3, 32'h8001_F07F, 32'h0,         32'hFFFF_FF80};
    vecs[2]  = '{1'b1, LD_H,   1'b1, 2'd2, 32'h8001_F07F, 32'h0,         32'h0000_8001};
    vecs[3]  = '{1'b1, LD_H,   1'b0, 2'd1, 32'h8001_F07F, 32'h0,         32'h0000_0000};
    vecs[4]  = '{1'b1, LD_B,   1'b0, 2'd0, 32'h8001_F07F, 32'h0,         32'h0000_007F};
    vecs[5]  = '{1'b1, LD_B,   1'b0, 2'd1, 32'h8001_F07F, 32'h0,         32'hFFFF_FFF0};
    vecs[6]  = '{1'b1, LD_B,   1'b1, 2'd1, 32'h8001_F07F, 32'h0,         32'h0000_00F0};
    vecs[7]  = '{1'b1, LD_H,   1'b0, 2'd0, 32'h8001_F07F, 32'h0,         32'hFFFF_F07F};
    vecs[8]  = '{1'b1, LD_H,   1'b0, 2'd2, 32'h8001_F07F, 32'h0,         32'hFFFF_8001};
    vecs[9]  = '{1'b1, LD_W,   1'b0, 2'd0, 32'h8001_F07F, 32'h0,         32'h8001_F07F};
    vecs[10] = '{1'b1, LD_W,   1'b0, 2'd2, 32'h8001_F07F, 32'h0,         32'h0000_0000};
    vecs[11] = '{1'b1, LD_RSV, 1'b0, 2'd0, 32'h8001_F07F, 32'h0,         32'h0000_0000};
    vecs[12] = '{1'b1, LD_W,   1'b1, 2'd0, 32'h8001_F07F, 32'h0,         32'h8001_F07F};

    // ---- reset state ----
    resetn     = 1'b0;
    rf_wready  = 1'b0;
    byp_raddr1 = 5'd0;
    byp_raddr2 = 5'd0;
    idle();
    tick();
    tick();
    settle();
    chk("rst_allow", 32'(a_allow), 32'h1);
    chk("rst_rf_we", 32'(a_rf_we), 32'h0);
    chk("rst_waddr", 32'(a_waddr), 32'h0);
    chk("rst_wdata", a_wdata, 32'h0);
    chk("rst_hit1",  32'(a_hit1), 32'h0);
    chk("rst_dpc",   a_dpc, 32'h0);
    chk("rst_dwen",  32'(a_dwen), 32'h0);
    resetn = 1'b1;
    tick();

    // ---- load alignment/extension sweep (DEPTH=2) ----
    for (int i = 0; i < NV; i++) begin
      in_valid       = 1'b1;
      in_pc          = 32'h2000 + 32'(4 * i);
      in_rf_we       = 1'b1;
      in_rd          = 5'd7;
      in_is_load     = vecs[i].is_load;
      in_ld_size     = vecs[i].size;
      in_ld_unsigned = vecs[i].uns;
      in_addr_lo     = vecs[i].lo;
      in_ram_rdata   = vecs[i].rdata;
      in_alu_result  = vecs[i].alu;
      rf_wready      = 1'b1;
      tick();
      idle();
      settle();
      chk($sformatf("vec%0d_rf_we", i), 32'(a_rf_we), 32'h1);
      chk($sformatf("vec%0d_wdata", i), a_wdata, vecs[i].exp);
      chk($sformatf("vec%0d_dwdata", i), a_dwdata, vecs[i].exp);
      tick();
    end

    // ---- backpressure (DEPTH=2) ----
    rf_wready = 1'b0;
    drive_alu(1'b1, 32'h300, 1'b1, 5'd1, 32'h101);
    settle();
    chk("bp_allow_1", 32'(a_allow), 32'h1);
    tick();
    drive_alu(1'b1, 32'h304, 1'b1, 5'd2, 32'h102);
    settle();
    chk("bp_allow_2", 32'(a_allow), 32'h1);
    chk("bp_lat_rf_we", 32'(a_rf_we), 32'h1);
    chk("bp_lat_waddr", 32'(a_waddr), 32'd1);
    tick();
    drive_alu(1'b1, 32'h308, 1'b1, 5'd3, 32'h103);
    settle();
    chk("bp_full_allow", 32'(a_allow), 32'h0);
    chk("bp_stall_dwen", 32'(a_dwen), 32'h0);
    tick();
    rf_wready = 1'b1;
    settle();
    chk("bp_pop_allow", 32'(a_allow), 32'h1);
    chk("bp_ret1_waddr", 32'(a_waddr), 32'd1);
    chk("bp_ret1_wdata", a_wdata, 32'h101);
    chk("bp_ret1_dpc", a_dpc, 32'h300);
    chk("bp_ret1_dwnum", 32'(a_dwnum), 32'd1);
    chk("bp_ret1_dwen", 32'(a_dwen), 32'hF);
    tick();
    idle();
    settle();
    chk("bp_ret2_rf_we", 32'(a_rf_we), 32'h1);
    chk("bp_ret2_waddr", 32'(a_waddr), 32'd2);
    chk("bp_ret2_wdata", a_wdata, 32'h102);
    tick();
    settle();
    chk("bp_ret3_waddr", 32'(a_waddr), 32'd3);
    chk("bp_ret3_wdata", a_wdata, 32'h103);
    tick();
    settle();
    chk("bp_empty_rf_we", 32'(a_rf_we), 32'h0);
    chk("bp_empty_waddr", 32'(a_waddr), 32'h0);

    // ---- youngest-wins bypass (DEPTH=2) ----
    rf_wready  = 1'b0;
    byp_raddr1 = 5'd5;
    byp_raddr2 = 5'd5;
    drive_alu(1'b1, 32'h500, 1'b1, 5'd5, 32'h11);
    settle();
    chk("byp_enq_invisible", 32'(a_hit1), 32'h0);
    tick();
    drive_alu(1'b1, 32'h504, 1'b1, 5'd5, 32'h22);
    settle();
    chk("byp_one_hit1", 32'(a_hit1), 32'h1);
    chk("byp_one_data1", a_data1, 32'h11);
    tick();
    idle();
    settle();
    chk("byp_young_hit1", 32'(a_hit1), 32'h1);
    chk("byp_young_data1", a_data1, 32'h22);
    chk("byp_young_data2", a_data2, 32'h22);
    byp_raddr2 = 5'd6;
    settle();
    chk("byp_miss_hit2", 32'(a_hit2), 32'h0);
    rf_wready = 1'b1;
    settle();
    chk("byp_ret1_data1", a_data1, 32'h22);
    tick();
    settle();
    chk("byp_ret2_hit1", 32'(a_hit1), 32'h1);
    chk("byp_ret2_data1", a_data1, 32'h22);
    tick();
    settle();
    chk("byp_gone_hit1", 32'(a_hit1), 32'h0);
    chk("byp_gone_data1", a_data1, 32'h0);

    // ---- r0 and non-writing instructions (DEPTH=2) ----
    rf_wready  = 1'b0;
    byp_raddr1 = 5'd0;
    drive_alu(1'b1, 32'h400, 1'b1, 5'd0, 32'hDEAD);
    tick();
    idle();
    settle();
    chk("r0_rf_we", 32'(a_rf_we), 32'h0);
    chk("r0_dwen", 32'(a_dwen), 32'h0);
    chk("r0_dpc", a_dpc, 32'h400);
    chk("r0_dwdata", a_dwdata, 32'hDEAD);
    chk("r0_hit1", 32'(a_hit1), 32'h0);
    tick();
    settle();
    chk("r0_gone_dpc", a_dpc, 32'h0);
    drive_alu(1'b1, 32'h404, 1'b0, 5'd4, 32'hBEEF);
    byp_raddr1 = 5'd4;
    tick();
    idle();
    settle();
    chk("nw_rf_we", 32'(a_rf_we), 32'h0);
    chk("nw_waddr", 32'(a_waddr), 32'd4);
    chk("nw_dwnum", 32'(a_dwnum), 32'd4);
    chk("nw_dwen", 32'(a_dwen), 32'h0);
    chk("nw_hit1", 32'(a_hit1), 32'h0);
    tick();

    // ---- wrap-around with random grants (DEPTH=4) ----
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    sent = 0;
    got  = 0;
    cyc  = 0;
    while (got < 10 && cyc < 400) begin
      rf_wready = 1'($urandom_range(0, 1));
      if (sent < 10)
        drive_alu(1'b1, 32'h1000 + 32'(4 * sent), 1'b1, 5'(sent + 1), 32'hA000 + 32'(sent));
      else
        idle();
      settle();
      if (exp_q.size() < 4) chk("wrap_allow", 32'(b_allow), 32'h1);
      if (b_rf_we && rf_wready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL wrap_spurious got waddr=%0d exp=no write", b_waddr);
        end else begin
          e = exp_q.pop_front();
          chk("wrap_waddr", 32'(b_waddr), 32'(e[36:32]));
          chk("wrap_wdata", b_wdata, e[31:0]);
          got++;
        end
      end
      if (in_valid && b_allow) begin
        exp_q.push_back({in_rd, in_alu_result});
        sent++;
      end
      tick();
      cyc++;
    end
    chk("wrap_count", 32'(got), 32'd10);
    chk("wrap_drained", 32'(exp_q.size()), 32'd0);
    idle();
    tick();

    // ---- reset mid-operation (DEPTH=2) ----
    rf_wready  = 1'b0;
    byp_raddr1 = 5'd8;
    drive_alu(1'b1, 32'h800, 1'b1, 5'd8, 32'h88);
    tick();
    drive_alu(1'b1, 32'h804, 1'b1, 5'd9, 32'h99);
    tick();
    idle();
    settle();
    chk("mr_pre_rf_we", 32'(a_rf_we), 32'h1);
    chk("mr_pre_hit1", 32'(a_hit1), 32'h1);
    resetn    = 1'b0;
    rf_wready = 1'b1;
    settle();
    chk("mr_rst_rf_we", 32'(a_rf_we), 32'h0);
    chk("mr_rst_dwen", 32'(a_dwen), 32'h0);
    chk("mr_rst_dpc", a_dpc, 32'h0);
    tick();
    resetn = 1'b1;
    settle();
    chk("mr_post_rf_we", 32'(a_rf_we), 32'h0);
    chk("mr_post_allow", 32'(a_allow), 32'h1);
    chk("mr_post_hit1", 32'(a_hit1), 32'h0);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("mr_quiet%0d_dwen", k), 32'(a_dwen), 32'h0);
      chk($sformatf("mr_quiet%0d_rf_we", k), 32'(a_rf_we), 32'h0);
      tick();
      settle();
    end

    // ---- final report ----
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_commit_buffer.md
Name: wb_commit_buffer

Overview:
- Parametrised successor to the single-register writeback stage.
- Accepts completed instructions from the MEM stage and performs load alignment and sign/zero extension at enqueue.
- Holds results in a DEPTH-entry in-order commit FIFO, so a shared regfile write port can apply backpressure without stalling MEM.
- Serves operand forwarding from every buffered entry, youngest first, and drives the golden-trace debug port on each retire.

Parameters:
- DEPTH, 2, commit FIFO entries; power of two, at least 1.
- RF_AW, 5, regfile address width.
- PC_W, 32, PC width carried for debug trace.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- in_valid  in  1  MEM has an instruction for WB.
- in_allow  out  1  WB accepts this cycle; transfer = in_valid & in_allow.
- in_pc  in  PC_W  instruction PC.
- in_rf_we  in  1  instruction writes the regfile.
- in_rd  in  RF_AW  destination register.
- in_is_load  in  1  result comes from data RAM, not ALU.
- in_ld_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- in_ld_unsigned  in  1  zero-extend instead of sign-extend.
- in_addr_lo  in  2  load address bits [1:0].
- in_ram_rdata  in  32  raw data RAM word.
- in_alu_result  in  32  ALU result.
- rf_we  out  1  regfile write request.
- rf_waddr  out  RF_AW  write address.
- rf_wdata  out  32  write data.
- rf_wready  in  1  regfile port granted this cycle.
- byp_raddr1, byp_raddr2  in  RF_AW  ID read addresses.
- byp_hit1, byp_hit2  out  1  a buffered entry will write that register.
- byp_data1, byp_data2  out  32  forwarded value.
- debug_wb_pc  out  32  retiring PC.
- debug_wb_rf_wen  out  4  write enable, replicated 4×.
- debug_wb_rf_wnum  out  5  retiring destination.
- debug_wb_rf_wdata  out  32  retiring data.

Behaviour:
- Reset: clk-synchronous while resetn=0.
  - count, head and tail pointers go to 0; all entry valid bits clear.
  - Every output then reads 0, except in_allow=1.
- Enqueue result:
  - in_is_load=0: alu_result.
  - Load, byte: lane = in_addr_lo.
  - Load, half: lane = in_addr_lo[1]; in_addr_lo[0]=1 gives 0.
  - Load, word: in_addr_lo≠0 gives 0.
  - in_ld_size=11 gives 0.
  - Extension is sign or zero per in_ld_unsigned; a word load passes unchanged.
- r0 entries: if in_rd==0, the stored rf_we is 0; the entry still occupies a slot and retires.
- Stored entry fields: pc, we, rd, final data.
- Retire (head valid): retire = head.we ? rf_wready : 1. Non-writing entries retire one per cycle with no grant.
- Write port: rf_we = head valid & head.we. rf_waddr and rf_wdata always show the head entry, or 0 when empty.
- Allow: in_allow = (count < DEPTH) | retire. This is a combinational path from rf_wready and is intended.
- Simultaneous enqueue and retire: count unchanged and both pointers advance.
- Enqueue into an empty FIFO: the entry is visible at the head the next cycle, so minimum latency is 1 cycle from transfer to rf_we.
- Pointers wrap modulo DEPTH. Full means count==DEPTH; empty means count==0.
- Bypass:
  - Scans all valid entries with we=1 and rd==byp_raddrN.
  - The youngest match (closest to tail) wins.
  - Purely combinational on registered state; an instruction being enqueued this cycle is not visible.
  - raddr==0 gives hit 0, data 0.
  - The head entry stays visible through its retire cycle.
- Debug, in the retire cycle only:
  - debug_wb_pc = head.pc.
  - debug_wb_rf_wen = {4{head.we}}.
  - debug_wb_rf_wnum = head.rd.
  - debug_wb_rf_wdata = head.data.
  - With no retire, all debug outputs are 0.
- Reset mid-operation discards buffered entries; no writes issue in the reset cycle.

Decomposition:
- Shared package or header holds:
  - the ld_size encodings (LD_B, LD_H, LD_W);
  - the entry field widths;
  - the trace wen width (4).
- One natural sub-module: load_align_ext. It is purely combinational, taking (rdata, size, unsigned, addr_lo) and producing a 32-bit result, and is reusable by the MEM stage.
- FIFO storage, pointers, retire logic and the bypass priority scan stay in wb_commit_buffer.

Test Plan:
- Load extension sweep (DEPTH=2):
  - rdata=0x8001_F07F, signed byte, addr_lo=3 → enqueued data 0xFFFFFF80.
  - Unsigned half, addr_lo=2 → 0x00008001.
  - Half with addr_lo=1 → 0.
- Backpressure (DEPTH=2), rf_wready=0, three back-to-back writes to r1, r2, r3:
  - in_allow drops after two accepts.
  - Raise rf_wready: r1 and r2 retire on consecutive cycles.
  - The third is accepted in the same cycle as the first retire (full + pop).
- Youngest-wins bypass:
  - Buffer holds r5=0x11 then r5=0x22, byp_raddr1=5 → hit1=1, data1=0x22.
  - After both retire → hit1=0.
- r0 and non-writing instructions:
  - in_rd=0 with in_alu_result=0xDEAD → rf_we never 1; retires with rf_wready=0.
  - debug_wb_rf_wen=0000; byp_raddr=0 gives hit 0.
- Wrap-around (DEPTH=4): 10 writes with random rf_wready → rf writes in order, with no loss or duplication.
- Reset mid-operation:
  - resetn=0 with 2 entries buffered → next cycle rf_we=0, in_allow=1, byp_hit=0.
  - No debug retire for the discarded entries.
